// File: rtl/dir_command_queue.sv
// Direction command FIFO between the button debouncers and the Snake game FSM.
// Filters duplicate/reversing presses on entry and releases one turn per game tick.
module dir_command_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [1:0] INIT_DIR = 2'b11,
    parameter int         CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                LeftPressed,
    input  logic                RightPressed,
    input  logic                UpPressed,
    input  logic                DownPressed,
    input  logic                Enable,
    input  logic                Restart,
    input  logic                GameTick,
    output logic [1:0]          CurrentDir,
    output logic                StepValid,
    output logic [CNT_BITS-1:0] Count,
    output logic                DropPulse
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS-1:0] LAST = PTR_BITS'(DEPTH - 1);

    logic [1:0]          mem [DEPTH];
    logic [PTR_BITS-1:0] head;
    logic [PTR_BITS-1:0] tail;
    logic [PTR_BITS-1:0] head_next;
    logic [PTR_BITS-1:0] tail_next;
    logic [PTR_BITS-1:0] tail_prev;

    logic       has_press;
    logic [1:0] cand;
    logic [1:0] ref_dir;
    logic       empty;
    logic       full;
    logic       tick;
    logic       pop;
    logic       bad_dir;
    logic       push;
    logic       drop;
    logic       flush;

    assign head_next = (head == LAST) ? '0 : head + PTR_BITS'(1);
    assign tail_next = (tail == LAST) ? '0 : tail + PTR_BITS'(1);
    assign tail_prev = (tail == '0) ? LAST : tail - PTR_BITS'(1);

    assign has_press = LeftPressed | RightPressed | UpPressed | DownPressed;

    // Priority Left > Right > Up > Down; losers vanish without a drop pulse.
    always_comb begin
        cand = 2'b01;
        if (LeftPressed)
            cand = 2'b10;
        else if (RightPressed)
            cand = 2'b11;
        else if (UpPressed)
            cand = 2'b00;
    end

    assign empty   = (Count == '0);
    assign full    = (Count == CNT_BITS'(DEPTH));
    assign ref_dir = empty ? CurrentDir : mem[tail_prev];
    assign flush   = Reset | Restart;

    assign tick    = Enable & GameTick;
    assign pop     = tick & ~empty;
    assign bad_dir = (cand[1] == ref_dir[1]);
    assign push    = Enable & has_press & ~bad_dir & (~full | pop);
    assign drop    = Enable & has_press & ~push;

    always_ff @(posedge Clock) begin
        if (push)
            mem[tail] <= cand;
    end

    always_ff @(posedge Clock) begin
        if (flush) begin
            CurrentDir <= INIT_DIR;
            Count      <= '0;
            head       <= '0;
            tail       <= '0;
            StepValid  <= 1'b0;
            DropPulse  <= 1'b0;
        end else begin
            StepValid <= tick;
            DropPulse <= drop;
            Count     <= Count + CNT_BITS'(push) - CNT_BITS'(pop);
            if (push)
                tail <= tail_next;
            if (pop) begin
                CurrentDir <= mem[head];
                head       <= head_next;
            end
        end
    end

endmodule

// File: tb/tb_dir_command_queue.sv
// Randomised and directed bench for dir_command_queue against a queue-based model.
module tb_dir_command_queue;

    localparam int         DEPTH    = 4;
    localparam logic [1:0] INIT_DIR = 2'b11;

    // Stimulus vector layout: {Enable, Reset, Restart, GameTick, L, R, U, D}
    localparam logic [7:0] E   = 8'h80;
    localparam logic [7:0] RST = 8'h40;
    localparam logic [7:0] RS  = 8'h20;
    localparam logic [7:0] T   = 8'h10;
    localparam logic [7:0] L   = 8'h08;
    localparam logic [7:0] R   = 8'h04;
    localparam logic [7:0] U   = 8'h02;
    localparam logic [7:0] D   = 8'h01;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       LeftPressed = 1'b0;
    logic       RightPressed = 1'b0;
    logic       UpPressed = 1'b0;
    logic       DownPressed = 1'b0;
    logic       Enable = 1'b0;
    logic       Restart = 1'b0;
    logic       GameTick = 1'b0;
    logic [1:0] CurrentDir;
    logic       StepValid;
    logic [2:0] Count;
    logic       DropPulse;

    int vectors = 0;
    int errors  = 0;

    logic [1:0] m_dir;
    logic [1:0] m_q[$];
    logic       m_sv;
    logic       m_drop;

    dir_command_queue #(
        .DEPTH(DEPTH),
        .INIT_DIR(INIT_DIR)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .LeftPressed(LeftPressed),
        .RightPressed(RightPressed),
        .UpPressed(UpPressed),
        .DownPressed(DownPressed),
        .Enable(Enable),
        .Restart(Restart),
        .GameTick(GameTick),
        .CurrentDir(CurrentDir),
        .StepValid(StepValid),
        .Count(Count),
        .DropPulse(DropPulse)
    );

    always #5 Clock = ~Clock;

    function automatic logic [6:0] obs();
        return {CurrentDir, StepValid, Count, DropPulse};
    endfunction

    function automatic logic [6:0] mexp();
        return {m_dir, m_sv, 3'(m_q.size()), m_drop};
    endfunction

    // Applies one cycle of stimulus and advances the behavioural model.
    task automatic step(input logic [7:0] v);
        logic [1:0] refd;
        logic [1:0] cand;
        logic       popping;
        logic       accept;
        {Enable, Reset, Restart, GameTick} = v[7:4];
        {LeftPressed, RightPressed, UpPressed, DownPressed} = v[3:0];
        @(posedge Clock);
        if (Reset || Restart) begin
            m_dir = INIT_DIR;
            m_q.delete();
            m_sv = 1'b0;
            m_drop = 1'b0;
        end else begin
            m_sv = Enable && GameTick;
            m_drop = 1'b0;
            accept = 1'b0;
            if (Enable) begin
                refd = (m_q.size() > 0) ? m_q[$] : m_dir;
                popping = GameTick && (m_q.size() > 0);
                cand = LeftPressed ? 2'b10 : RightPressed ? 2'b11 :
                       UpPressed ? 2'b00 : 2'b01;
                if (v[3:0] != 4'b0) begin
                    if (cand == refd || cand == (refd ^ 2'b01))
                        m_drop = 1'b1;
                    else if (m_q.size() == DEPTH && !popping)
                        m_drop = 1'b1;
                    else
                        accept = 1'b1;
                end
                if (popping)
                    m_dir = m_q.pop_front();
                if (accept)
                    m_q.push_back(cand);
            end
        end
        #1;
        {Reset, Restart, GameTick} = 3'b0;
        {LeftPressed, RightPressed, UpPressed, DownPressed} = 4'b0;
    endtask

    task automatic test_reset();
        step(E | U | L);
        step(E | RST | T | D);
        vectors++;
        if (obs() !== {INIT_DIR, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset got=%b exp=%b", obs(), {INIT_DIR, 5'b0});
        end
    endtask

    task automatic test_idle_tick();
        logic [7:0] seq [4] = '{E | RST, E | T, E, E | T};
        logic [6:0] exp [4] = '{7'b11_0_000_0, 7'b11_1_000_0,
                                7'b11_0_000_0, 7'b11_1_000_0};
        for (int i = 0; i < 4; i++) begin
            step(seq[i]);
            vectors += 2;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL idle_tick[%0d] got=%b exp=%b", i, obs(), exp[i]);
            end
            if (obs() !== mexp()) begin
                errors++;
                $display("FAIL idle_tick_model[%0d] got=%b exp=%b", i, obs(), mexp());
            end
        end
    endtask

    task automatic test_two_turns();
        logic [7:0] seq [7] = '{E | RST, E | U, E, E, E | L, E | T, E | T};
        logic [6:0] exp [7] = '{7'b11_0_000_0, 7'b11_0_001_0, 7'b11_0_001_0,
                                7'b11_0_001_0, 7'b11_0_010_0, 7'b00_1_001_0,
                                7'b10_1_000_0};
        for (int i = 0; i < 7; i++) begin
            step(seq[i]);
            vectors += 2;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL two_turns[%0d] got=%b exp=%b", i, obs(), exp[i]);
            end
            if (obs() !== mexp()) begin
                errors++;
                $display("FAIL two_turns_model[%0d] got=%b exp=%b", i, obs(), mexp());
            end
        end
    endtask

    task automatic test_reject();
        logic [7:0] seq [4] = '{E | RST, E | L, E | R, E};
        logic [6:0] exp [4] = '{7'b11_0_000_0, 7'b11_0_000_1,
                                7'b11_0_000_1, 7'b11_0_000_0};
        for (int i = 0; i < 4; i++) begin
            step(seq[i]);
            vectors += 2;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL reject[%0d] got=%b exp=%b", i, obs(), exp[i]);
            end
            if (obs() !== mexp()) begin
                errors++;
                $display("FAIL reject_model[%0d] got=%b exp=%b", i, obs(), mexp());
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] seq [11] = '{E | RST, E | U, E | L, E | D, E | R, E | U,
                                 E | T, E | T, E | T, E | T, E};
        logic [6:0] exp [11] = '{7'b11_0_000_0, 7'b11_0_001_0, 7'b11_0_010_0,
                                 7'b11_0_011_0, 7'b11_0_100_0, 7'b11_0_100_1,
                                 7'b00_1_011_0, 7'b10_1_010_0, 7'b01_1_001_0,
                                 7'b11_1_000_0, 7'b11_0_000_0};
        for (int i = 0; i < 11; i++) begin
            step(seq[i]);
            vectors += 2;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL overflow[%0d] got=%b exp=%b", i, obs(), exp[i]);
            end
            if (obs() !== mexp()) begin
                errors++;
                $display("FAIL overflow_model[%0d] got=%b exp=%b", i, obs(), mexp());
            end
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] seq [8] = '{E | RST, E | U, E | L, E | D, E | R,
                                E | U | T, E, E | T};
        logic [6:0] exp [8] = '{7'b11_0_000_0, 7'b11_0_001_0, 7'b11_0_010_0,
                                7'b11_0_011_0, 7'b11_0_100_0, 7'b00_1_100_0,
                                7'b00_0_100_0, 7'b10_1_011_0};
        for (int i = 0; i < 8; i++) begin
            step(seq[i]);
            vectors += 2;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL full_push_pop[%0d] got=%b exp=%b", i, obs(), exp[i]);
            end
            if (obs() !== mexp()) begin
                errors++;
                $display("FAIL full_push_pop_model[%0d] got=%b exp=%b", i, obs(), mexp());
            end
        end
    endtask

    task automatic test_restart();
        logic [7:0] seq [9] = '{E | RST, E | U, E | L, E | D, E | RS | U | T,
                                E | U, E | L, E | D, E | RST | U | T};
        logic [6:0] exp [9] = '{7'b11_0_000_0, 7'b11_0_001_0, 7'b11_0_010_0,
                                7'b11_0_011_0, 7'b11_0_000_0, 7'b11_0_001_0,
                                7'b11_0_010_0, 7'b11_0_011_0, 7'b11_0_000_0};
        for (int i = 0; i < 9; i++) begin
            step(seq[i]);
            vectors += 2;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL restart[%0d] got=%b exp=%b", i, obs(), exp[i]);
            end
            if (obs() !== mexp()) begin
                errors++;
                $display("FAIL restart_model[%0d] got=%b exp=%b", i, obs(), mexp());
            end
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [6] = '{E | RST, E | U, E | L, T | R, T | D, E | T};
        logic [6:0] exp [6] = '{7'b11_0_000_0, 7'b11_0_001_0, 7'b11_0_010_0,
                                7'b11_0_010_0, 7'b11_0_010_0, 7'b00_1_001_0};
        for (int i = 0; i < 6; i++) begin
            step(seq[i]);
            vectors += 2;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL pause[%0d] got=%b exp=%b", i, obs(), exp[i]);
            end
            if (obs() !== mexp()) begin
                errors++;
                $display("FAIL pause_model[%0d] got=%b exp=%b", i, obs(), mexp());
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        step(E | RST);
        for (int i = 0; i < 3000; i++) begin
            v = '0;
            v[7] = ($urandom_range(9) != 0);
            v[6] = ($urandom_range(199) == 0);
            v[5] = ($urandom_range(99) == 0);
            v[4] = ($urandom_range(4) == 0);
            for (int b = 0; b < 4; b++)
                v[b] = ($urandom_range(3) == 0);
            step(v);
            vectors++;
            if (obs() !== mexp()) begin
                errors++;
                $display("FAIL random[%0d] in=%b got=%b exp=%b", i, v, obs(), mexp());
            end
        end
    endtask

    initial begin
        m_dir = INIT_DIR;
        m_sv = 1'b0;
        m_drop = 1'b0;
        test_reset();
        test_idle_tick();
        test_two_turns();
        test_reject();
        test_overflow();
        test_full_push_pop();
        test_restart();
        test_pause();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dir_command_queue.md
Name: dir_command_queue

Overview:
- Sits between the five button Debouncers and the game-state FSM in Snake.
- Captures debounced direction presses into a small FIFO, so fast multi-key turns such as up-then-left inside one game tick are not lost.
- Rejects duplicate and reversing presses at enqueue time.
- Pops one command per game tick and presents the direction for that step to the game FSM.

Parameters:
- DEPTH, 4: FIFO entries, from 2 to 8.
- INIT_DIR, 2'b11: direction loaded on reset or restart (right).
- CNT_BITS, $clog2(DEPTH+1): width of Count.

Ports:
- Clock, input, 1: system clock, the divided `clock` domain.
- Reset, input, 1: synchronous, active-high.
- LeftPressed, input, 1: one-cycle pulse from the left debouncer.
- RightPressed, input, 1: one-cycle pulse from the right debouncer.
- UpPressed, input, 1: one-cycle pulse from the up debouncer.
- DownPressed, input, 1: one-cycle pulse from the down debouncer.
- Enable, input, 1: high while the game is in STATE_ALIVE.
- Restart, input, 1: one-cycle pulse; flush the queue and reload INIT_DIR.
- GameTick, input, 1: one-cycle step strobe from gameClock.
- CurrentDir, output, 2: direction for the current or next step.
- StepValid, output, 1: one-cycle pulse; CurrentDir is valid for this step.
- Count, output, CNT_BITS: number of occupied entries.
- DropPulse, output, 1: one-cycle pulse; a press was discarded.

Behaviour:
- Encoding follows the DIR_* macros in Constants.v: up=2'b00, down=2'b01, left=2'b10, right=2'b11. "Opposite" means the two values differ only in bit 0.
- Reset, synchronous and highest priority:
  - CurrentDir=INIT_DIR, Count=0.
  - Head and tail pointers = 0.
  - StepValid=0, DropPulse=0.
  - Storage contents are don't-care.
- Restart=1 while Reset=0: same effect as Reset. Overrides any press or tick in the same cycle.
- Enable=0:
  - Presses are ignored, with no DropPulse.
  - Ticks are ignored, with no pop and no StepValid.
  - Queue contents and CurrentDir are held, which gives pause semantics.
- Press selection:
  - If several press inputs are high in one cycle, exactly one is taken, with priority Left > Right > Up > Down.
  - The others are discarded silently, with no DropPulse.
- Reference direction (ref):
  - If Count>0, ref = the tail entry, i.e. the most recently queued entry.
  - Otherwise ref = CurrentDir.
  - ref always uses pre-update state for that cycle.
- Enqueue of candidate d, only when Enable=1:
  - If d==ref or d==opposite(ref): reject. DropPulse=1 next cycle.
  - Else if Count==DEPTH and no pop this cycle: reject as full. DropPulse=1 next cycle.
  - Else: write d at the tail and advance the tail pointer, wrapping modulo DEPTH.
- Pop, on a cycle N with GameTick=1 and Enable=1:
  - If Count>0: CurrentDir <= head entry and the head pointer advances, wrapping.
  - If Count==0: CurrentDir is held.
  - In both cases StepValid=1 in cycle N+1 only, with CurrentDir already updated. Latency from tick to pulse is 1 cycle.
- Simultaneous push and pop:
  - Both occur and Count is unchanged.
  - When full, the push is accepted because a slot frees in the same cycle.
  - When Count==1, ref is the popped entry, and that entry is the new CurrentDir. This is consistent.
- Count:
  - Count += push - pop.
  - It never exceeds DEPTH and never underflows.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Game FSM contract: apply a move only on StepValid, using CurrentDir.

Test Plan:
- Reset, then Enable=1 and GameTick pulsed with no presses -> StepValid high 1 cycle after the tick, CurrentDir=2'b11, Count=0, DropPulse never asserted.
- From CurrentDir=right: UpPressed, then LeftPressed 3 cycles later, then two ticks -> Count goes 1,2. After tick 1: CurrentDir=00. After tick 2: CurrentDir=10, Count=0.
- From CurrentDir=right: LeftPressed (reversal), then RightPressed (duplicate) -> DropPulse once for each, Count stays 0, CurrentDir stays 11.
- Overflow with DEPTH=4: presses up, left, down, right, up -> first four accepted, Count=4. The fifth gives DropPulse=1, Count=4. Four ticks then pop 00, 10, 01, 11 in order, wrapping correctly.
- Full queue, then a press that passes the reversal check arrives in the same cycle as GameTick -> both push and pop occur, Count stays 4, DropPulse=0, StepValid the next cycle.
- Count=3 mid-game, then Restart pulsed together with UpPressed and GameTick -> next cycle Count=0, CurrentDir=11, StepValid=0, DropPulse=0. Same result using Reset instead of Restart.
